// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder (DIGIT bits per clock, LSB first) with start/busy/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             cout,
   output logic             ovf
`else
   output logic             cout
`endif
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
      $error("serial_adder: DIGIT must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] op_a, op_b, res, res_n;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] s;
   logic             carry, c, last;

   // Result shifts in from the top so the last digit lands it fully aligned.
   always_comb begin
      last = cnt == LAST;
      {c, s} = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      res_n = WIDTH'({s, res} >> DIGIT);
      state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a  <= '0;
         op_b  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (state == RUN) begin
         op_a  <= op_a >> DIGIT;
         op_b  <= op_b >> DIGIT;
         res   <= res_n;
         carry <= c;
         cnt   <= last ? '0 : cnt + CW'(1);
         if (last) begin
            sum  <= res_n;
            cout <= c;
         end
      end else if (start) begin
         op_a  <= a;
         op_b  <= b;
         carry <= cin;
         cnt   <= '0;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // Carry into the MSB recovered from the final slice's top sum bit.
   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (state == RUN && last)
         ovf <= s[DIGIT-1] ^ op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ c;
   end
`endif

   assign busy = state == RUN;
   assign done = state == DONE;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed scoreboard bench over three serial_adder configurations.
module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] start = '0;
   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic [2:0] busy, done, cout, ovf;
   logic       sum1;
   logic [7:0] sum8, sum4;
   int         vec = 0, errs = 0, cyc = 0, dn;

   typedef struct {
      int         u;
      int         n;
      int         t0;
      logic [7:0] s;
      logic       c;
      logic       v;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
      .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .cin(cin),
      .busy(busy[0]), .done(done[0]), .sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf(ovf[0]),
`endif
      .cout(cout[0]));

   serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst(rst), .start(start[1]), .a(a), .b(b), .cin(cin),
      .busy(busy[1]), .done(done[1]), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf(ovf[1]),
`endif
      .cout(cout[1]));

   serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
      .clk(clk), .rst(rst), .start(start[2]), .a(a), .b(b), .cin(cin),
      .busy(busy[2]), .done(done[2]), .sum(sum4),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf(ovf[2]),
`endif
      .cout(cout[2]));

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf = '0;
`endif

   function automatic logic [7:0] sum_of(input int u);
      return u == 0 ? {7'b0, sum1} : (u == 1 ? sum8 : sum4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one accepted start and queue its expected result.
   task automatic go(input int u, input logic [7:0] av, input logic [7:0] bv, input logic cv);
      exp_t       e;
      logic [8:0] full;
      e.u = u;
      e.n = u == 0 ? 1 : (u == 1 ? 8 : 2);
      if (u == 0) begin
         full = 9'(av[0]) + 9'(bv[0]) + 9'(cv);
         e.s = {7'b0, full[0]};
         e.c = full[1];
         e.v = av[0] == bv[0] && full[0] != av[0];
      end else begin
         full = 9'(av) + 9'(bv) + 9'(cv);
         e.s = full[7:0];
         e.c = full[8];
         e.v = av[7] == bv[7] && full[7] != av[7];
      end
      a = av;
      b = bv;
      cin = cv;
      start[u] = 1'b1;
      tick;
      start[u] = 1'b0;
      e.t0 = cyc;
      q.push_back(e);
      chk("busy_after_start", 32'(busy[u]), 1);
   endtask

   task automatic wait_done;
      exp_t e;
      e = q.pop_front();
      while (!done[e.u] && cyc - e.t0 < 40) tick;
      chk("latency", cyc - e.t0, e.n);
      chk("sum", 32'(sum_of(e.u)), 32'(e.s));
      chk("cout", 32'(cout[e.u]), 32'(e.c));
      chk("busy_in_done", 32'(busy[e.u]), 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 32'(ovf[e.u]), 32'(e.v));
`endif
   endtask

   initial begin
      tick;
      tick;
      for (int u = 0; u < 3; u++) begin
         chk("rst_busy", 32'(busy[u]), 0);
         chk("rst_done", 32'(done[u]), 0);
         chk("rst_sum", 32'(sum_of(u)), 0);
         chk("rst_cout", 32'(cout[u]), 0);
      end
      rst = 1'b0;
      tick;
      // Full-adder truth table on the single-bit configuration
      for (int i = 0; i < 8; i++) begin
         logic [2:0] p;
         p = 3'(i);
         go(0, {7'b0, p[2]}, {7'b0, p[1]}, p[0]);
         wait_done;
         tick;
         chk("done_pulse_w1", 32'(done[0]), 0);
      end
      // Bit-serial, then back-to-back start in the DONE cycle
      go(1, 8'hFF, 8'h01, 1'b0);
      wait_done;
      go(1, 8'hFF, 8'hFF, 1'b1);
      wait_done;
      tick;
      chk("done_pulse_w8", 32'(done[1]), 0);
      // Nibble-serial: busy for exactly two cycles
      go(2, 8'h5A, 8'h3C, 1'b0);
      tick;
      chk("busy_second_cycle", 32'(busy[2]), 1);
      wait_done;
      // Start during RUN is ignored and sum holds the prior result
      go(1, 8'h10, 8'h20, 1'b0);
      tick;
      tick;
      a = 8'hFF;
      b = 8'hFF;
      start[1] = 1'b1;
      tick;
      start[1] = 1'b0;
      chk("busy_ignore", 32'(busy[1]), 1);
      chk("sum_hold", 32'(sum8), 32'h0FF);
      chk("cout_hold", 32'(cout[1]), 1);
      wait_done;
      tick;
      // Reset in the middle of a run discards it
      go(1, 8'hAA, 8'h55, 1'b0);
      tick;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      void'(q.pop_back());
      chk("midrst_busy", 32'(busy[1]), 0);
      chk("midrst_done", 32'(done[1]), 0);
      chk("midrst_sum", 32'(sum8), 0);
      chk("midrst_cout", 32'(cout[1]), 0);
      dn = 0;
      repeat (20) begin
         tick;
         if (done[1]) dn++;
      end
      chk("no_done_after_rst", dn, 0);
      go(1, 8'h01, 8'h01, 1'b0);
      wait_done;
      tick;
      // Signed-overflow corners
      go(1, 8'h7F, 8'h01, 1'b0);
      wait_done;
      go(1, 8'h80, 8'h80, 1'b0);
      wait_done;
      go(1, 8'hFF, 8'h01, 1'b0);
      wait_done;
      tick;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
